// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matmul sequencer slice.
// Holds array geometry, counter widths, the sequencer state encoding and
// the feed-length helper used to size the skewed feed window.
package matmul_pkg;

  localparam int unsigned DW       = 8;                   // bits per matrix element
  localparam int unsigned BW       = 32;                  // accumulator/bus width
  localparam int unsigned MAX_DIM  = BW / DW;             // array side
  localparam int unsigned DIM_W    = $clog2(MAX_DIM);     // field value d encodes dimension d+1
  localparam int unsigned PIPE_LAT = 1;                   // PE pipeline cycles drained after last feed
  localparam int unsigned CNT_W    = $clog2(3 * MAX_DIM); // step counter width
  localparam int unsigned CW1      = CNT_W + 1;           // headroom width for skew compares

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_C,
    FEED,
    DRAIN,
    DONE
  } state_e;

  // Number of FEED steps: K + (N-1) + (M-1), with dim fields holding d-1.
  function automatic logic [CNT_W-1:0] feed_len(input logic [DIM_W-1:0] n,
                                                 input logic [DIM_W-1:0] k,
                                                 input logic [DIM_W-1:0] m);
    logic [CW1-1:0] sum;
    sum = CW1'(k) + CW1'(1) + CW1'(n) + CW1'(m);
    return CNT_W'(sum);
  endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Control/status bundle between the APB register file, the sequencer and the
// padding/calc datapath.
//   master : sequencer side (consumes start/dims, drives strobes and masks)
//   slave  : register file / datapath side
//   start_i             control_reg[0] level
//   n/k/m_dim_i         matrix dims minus 1
//   bias_en_i           add operand C
//   busy_o, done_o      run status, 1-cycle completion pulse
//   clr_acc_o, load_c_o 1-cycle accumulator clear / bias load strobes
//   feed_en_o, step_o   feed valid and current feed step
//   row_en_o, col_en_o  skewed per-row / per-column feed enables
//   err_o               start edge seen while a run was active
interface matmul_seq_if;
  import matmul_pkg::*;

  logic               start_i;
  logic [DIM_W-1:0]   n_dim_i;
  logic [DIM_W-1:0]   k_dim_i;
  logic [DIM_W-1:0]   m_dim_i;
  logic               bias_en_i;
  logic               busy_o;
  logic               clr_acc_o;
  logic               load_c_o;
  logic               feed_en_o;
  logic [CNT_W-1:0]   step_o;
  logic [MAX_DIM-1:0] row_en_o;
  logic [MAX_DIM-1:0] col_en_o;
  logic               done_o;
  logic               err_o;

  modport master (
    input  start_i, n_dim_i, k_dim_i, m_dim_i, bias_en_i,
    output busy_o, clr_acc_o, load_c_o, feed_en_o, step_o,
           row_en_o, col_en_o, done_o, err_o
  );

  modport slave (
    output start_i, n_dim_i, k_dim_i, m_dim_i, bias_en_i,
    input  busy_o, clr_acc_o, load_c_o, feed_en_o, step_o,
           row_en_o, col_en_o, done_o, err_o
  );

endinterface

// File: rtl/matmul_skew_mask.sv
// Combinational skew mask for one edge of the systolic array.
// Lane i is enabled at feed step t when i < dim, t >= i and t < i + K.
//   t_i   : current feed step
//   dim_i : lane count field (value d means d+1 lanes)
//   k_i   : shared dimension field (value d means K = d+1)
//   en_o  : per-lane enable vector
module matmul_skew_mask
  import matmul_pkg::*;
(
  input  logic [CNT_W-1:0]   t_i,
  input  logic [DIM_W-1:0]   dim_i,
  input  logic [DIM_W-1:0]   k_i,
  output logic [MAX_DIM-1:0] en_o
);

  logic [CW1-1:0] t_w;
  logic [CW1-1:0] d_w;
  logic [CW1-1:0] k_w;
  logic [CW1-1:0] idx;

  // One extra bit so i + K never wraps.
  assign t_w = CW1'(t_i);
  assign d_w = CW1'(dim_i) + CW1'(1);
  assign k_w = CW1'(k_i) + CW1'(1);

  always_comb begin
    en_o = '0;
    idx  = '0;
    for (int unsigned i = 0; i < MAX_DIM; i++) begin
      idx     = CW1'(i);
      en_o[i] = (idx < d_w) && (t_w >= idx) && (t_w < idx + k_w);
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Cycle-accurate sequencer for the systolic matmul datapath.
// Edge-detects start, latches N/K/M/bias, clears accumulators, optionally
// loads bias C, emits skewed feed enables for K+(N-1)+(M-1) steps, drains the
// PE pipe and pulses done. All outputs are registered (Moore).
//   clk_i    : clock, rising edge
//   reset_ni : asynchronous active-low reset (release expected synchronous)
//   bus      : control/status bundle, sequencer side
module matmul_seq
  import matmul_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_ni,
  matmul_seq_if.master bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q;
  logic               rise;
  logic [DIM_W-1:0]   n_q, k_q, m_q;
  logic               bias_q;
  logic [CNT_W-1:0]   t_len;
  logic [MAX_DIM-1:0] row_mask, col_mask;
  logic               feed_d;

  logic               busy_r, clr_r, load_r, feed_r, done_r, err_r;
  logic [CNT_W-1:0]   step_r;
  logic [MAX_DIM-1:0] row_r, col_r;

  assign rise   = bus.start_i & ~start_q;
  assign t_len  = feed_len(n_q, k_q, m_q);
  assign feed_d = (state_d == FEED);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = bias_q ? LOAD_C : FEED;
      end
      LOAD_C: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        if (cnt_q == t_len - CNT_W'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Masks are evaluated on the next step so they land in the same register
  // stage as feed_en/step, keeping every output a clean Moore output.
  matmul_skew_mask u_row_mask (
    .t_i   (cnt_d),
    .dim_i (n_q),
    .k_i   (k_q),
    .en_o  (row_mask)
  );

  matmul_skew_mask u_col_mask (
    .t_i   (cnt_d),
    .dim_i (m_q),
    .k_i   (k_q),
    .en_o  (col_mask)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      n_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      bias_q  <= 1'b0;
      busy_r  <= 1'b0;
      clr_r   <= 1'b0;
      load_r  <= 1'b0;
      feed_r  <= 1'b0;
      step_r  <= '0;
      row_r   <= '0;
      col_r   <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      start_q <= bus.start_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == IDLE) && rise) begin
        n_q    <= bus.n_dim_i;
        k_q    <= bus.k_dim_i;
        m_q    <= bus.m_dim_i;
        bias_q <= bus.bias_en_i;
      end
      busy_r <= state_d inside {CLEAR, LOAD_C, FEED, DRAIN};
      clr_r  <= (state_d == CLEAR);
      load_r <= (state_d == LOAD_C);
      feed_r <= feed_d;
      step_r <= feed_d ? cnt_d : '0;
      row_r  <= feed_d ? row_mask : '0;
      col_r  <= feed_d ? col_mask : '0;
      done_r <= (state_d == DONE);
      err_r  <= rise && (state_q != IDLE);
    end
  end

  assign bus.busy_o    = busy_r;
  assign bus.clr_acc_o = clr_r;
  assign bus.load_c_o  = load_r;
  assign bus.feed_en_o = feed_r;
  assign bus.step_o    = step_r;
  assign bus.row_en_o  = row_r;
  assign bus.col_en_o  = col_r;
  assign bus.done_o    = done_r;
  assign bus.err_o     = err_r;

endmodule

// File: tb/tb_matmul_seq.sv
module tb_matmul_seq;
  import matmul_pkg::*;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  matmul_seq_if bus ();

  matmul_seq u_dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus.master)
  );

  int checks = 0;
  int errors = 0;

  localparam int NREC = 64;
  localparam int S_BUSY = 0, S_CLR = 1, S_LDC = 2, S_FEED = 3, S_DONE = 4, S_ERR = 5;

  logic               rec_busy [NREC];
  logic               rec_clr  [NREC];
  logic               rec_ldc  [NREC];
  logic               rec_feed [NREC];
  logic               rec_done [NREC];
  logic               rec_err  [NREC];
  logic [CNT_W-1:0]   rec_step [NREC];
  logic [MAX_DIM-1:0] rec_row  [NREC];
  logic [MAX_DIM-1:0] rec_col  [NREC];

  typedef struct {
    logic [1:0] n, k, m;
    logic       bias;
    int         feed_first;
    int         feed_cnt;
    int         done_cyc;
  } run_vec_t;

  typedef struct {
    logic [1:0] n, k, m;
    int         t;
    logic [3:0] row;
    logic [3:0] col;
  } mask_vec_t;

  run_vec_t  runs  [6];
  mask_vec_t masks [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.busy_o, bus.clr_acc_o, bus.load_c_o, bus.feed_en_o, bus.done_o,
                 bus.err_o, bus.step_o, bus.row_en_o, bus.col_en_o});
  endfunction

  function automatic logic sig(input int sel, input int c);
    case (sel)
      S_BUSY:  return rec_busy[c];
      S_CLR:   return rec_clr[c];
      S_LDC:   return rec_ldc[c];
      S_FEED:  return rec_feed[c];
      S_DONE:  return rec_done[c];
      S_ERR:   return rec_err[c];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int first_set(input int sel, input int lo, input int hi);
    for (int c = lo; c < hi; c++) if (sig(sel, c)) return c;
    return -1;
  endfunction

  function automatic int count_set(input int sel, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c < hi; c++) if (sig(sel, c)) n++;
    return n;
  endfunction

  // Entered at posedge+1; cycle c samples outputs, then drives start_i = pat[c].
  // Dims/bias are scrambled for cycles 1..7 to show they are ignored mid-run.
  task automatic record(input logic [NREC-1:0] pat, input int ncyc);
    logic [1:0] sn, sk, sm;
    logic       sb;
    sn = bus.n_dim_i; sk = bus.k_dim_i; sm = bus.m_dim_i; sb = bus.bias_en_i;
    for (int c = 0; c < NREC; c++) begin
      rec_busy[c] = 1'b0; rec_clr[c] = 1'b0; rec_ldc[c] = 1'b0; rec_feed[c] = 1'b0;
      rec_done[c] = 1'b0; rec_err[c] = 1'b0; rec_step[c] = '0; rec_row[c] = '0; rec_col[c] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      rec_busy[c] = bus.busy_o;    rec_clr[c]  = bus.clr_acc_o;
      rec_ldc[c]  = bus.load_c_o;  rec_feed[c] = bus.feed_en_o;
      rec_done[c] = bus.done_o;    rec_err[c]  = bus.err_o;
      rec_step[c] = bus.step_o;    rec_row[c]  = bus.row_en_o;
      rec_col[c]  = bus.col_en_o;
      bus.start_i = pat[c];
      if (c == 1) begin
        bus.n_dim_i = ~sn; bus.k_dim_i = ~sk; bus.m_dim_i = ~sm; bus.bias_en_i = ~sb;
      end else if (c == 8) begin
        bus.n_dim_i = sn; bus.k_dim_i = sk; bus.m_dim_i = sm; bus.bias_en_i = sb;
      end
      @(posedge clk_i); #1;
    end
    bus.start_i = 1'b0;
    bus.n_dim_i = sn; bus.k_dim_i = sk; bus.m_dim_i = sm; bus.bias_en_i = sb;
  endtask

  task automatic set_dims(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                          input logic b);
    bus.n_dim_i = n; bus.k_dim_i = k; bus.m_dim_i = m; bus.bias_en_i = b;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ff, fc, dc;
    logic [NREC-1:0] pat;

    // dims fields hold (dimension - 1)
    runs[0] = '{n:2'd3, k:2'd3, m:2'd3, bias:1'b0, feed_first:2, feed_cnt:10, done_cyc:13};
    runs[1] = '{n:2'd1, k:2'd2, m:2'd3, bias:1'b0, feed_first:2, feed_cnt:7,  done_cyc:10};
    runs[2] = '{n:2'd0, k:2'd0, m:2'd0, bias:1'b1, feed_first:3, feed_cnt:1,  done_cyc:5};
    runs[3] = '{n:2'd0, k:2'd0, m:2'd0, bias:1'b0, feed_first:2, feed_cnt:1,  done_cyc:4};
    runs[4] = '{n:2'd2, k:2'd1, m:2'd0, bias:1'b1, feed_first:3, feed_cnt:4,  done_cyc:8};
    runs[5] = '{n:2'd3, k:2'd0, m:2'd3, bias:1'b0, feed_first:2, feed_cnt:7,  done_cyc:10};

    masks[0]  = '{n:2'd1, k:2'd2, m:2'd3, t:0, row:4'b0001, col:4'b0001};
    masks[1]  = '{n:2'd1, k:2'd2, m:2'd3, t:2, row:4'b0011, col:4'b0111};
    masks[2]  = '{n:2'd1, k:2'd2, m:2'd3, t:3, row:4'b0010, col:4'b1110};
    masks[3]  = '{n:2'd1, k:2'd2, m:2'd3, t:4, row:4'b0000, col:4'b1100};
    masks[4]  = '{n:2'd1, k:2'd2, m:2'd3, t:5, row:4'b0000, col:4'b1000};
    masks[5]  = '{n:2'd3, k:2'd3, m:2'd3, t:0, row:4'b0001, col:4'b0001};
    masks[6]  = '{n:2'd3, k:2'd3, m:2'd3, t:3, row:4'b1111, col:4'b1111};
    masks[7]  = '{n:2'd3, k:2'd3, m:2'd3, t:6, row:4'b1000, col:4'b1000};
    masks[8]  = '{n:2'd3, k:2'd3, m:2'd3, t:9, row:4'b0000, col:4'b0000};
    masks[9]  = '{n:2'd3, k:2'd0, m:2'd3, t:2, row:4'b0100, col:4'b0100};
    masks[10] = '{n:2'd0, k:2'd0, m:2'd0, t:0, row:4'b0001, col:4'b0001};
    masks[11] = '{n:2'd2, k:2'd1, m:2'd0, t:2, row:4'b0110, col:4'b0000};

    bus.start_i = 1'b0;
    set_dims(2'd0, 2'd0, 2'd0, 1'b0);
    reset_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", all_outs(), 0);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int v = 0; v < 6; v++) begin
      ff = runs[v].feed_first; fc = runs[v].feed_cnt; dc = runs[v].done_cyc;
      set_dims(runs[v].n, runs[v].k, runs[v].m, runs[v].bias);
      record(64'h1, 20);
      chk($sformatf("v%0d_busy_rise", v), first_set(S_BUSY, 0, 20), 1);
      chk($sformatf("v%0d_busy_len", v), count_set(S_BUSY, 0, 20), dc - 1);
      chk($sformatf("v%0d_clr_cyc", v), first_set(S_CLR, 0, 20), 1);
      chk($sformatf("v%0d_clr_cnt", v), count_set(S_CLR, 0, 20), 1);
      chk($sformatf("v%0d_ldc_cyc", v), first_set(S_LDC, 0, 20), runs[v].bias ? 2 : -1);
      chk($sformatf("v%0d_ldc_cnt", v), count_set(S_LDC, 0, 20), int'(runs[v].bias));
      chk($sformatf("v%0d_feed_first", v), first_set(S_FEED, 0, 20), ff);
      chk($sformatf("v%0d_feed_cnt", v), count_set(S_FEED, 0, 20), fc);
      chk($sformatf("v%0d_step_last", v), int'(rec_step[ff + fc - 1]), fc - 1);
      chk($sformatf("v%0d_done_cyc", v), first_set(S_DONE, 0, 20), dc);
      chk($sformatf("v%0d_done_cnt", v), count_set(S_DONE, 0, 20), 1);
      chk($sformatf("v%0d_busy_at_done", v), int'(rec_busy[dc]), 0);
      chk($sformatf("v%0d_err_cnt", v), count_set(S_ERR, 0, 20), 0);
      for (int j = 0; j < 12; j++) begin
        if (masks[j].n == runs[v].n && masks[j].k == runs[v].k && masks[j].m == runs[v].m) begin
          chk($sformatf("v%0d_t%0d_step", v, masks[j].t), int'(rec_step[ff + masks[j].t]), masks[j].t);
          chk($sformatf("v%0d_t%0d_row", v, masks[j].t), int'(rec_row[ff + masks[j].t]), int'(masks[j].row));
          chk($sformatf("v%0d_t%0d_col", v, masks[j].t), int'(rec_col[ff + masks[j].t]), int'(masks[j].col));
        end
      end
      chk($sformatf("v%0d_idle_after", v), all_outs(), 0);
    end

    // Second rise during FEED: err pulse, run unaffected.
    set_dims(2'd3, 2'd3, 2'd3, 1'b0);
    record(64'h13, 24);
    chk("dup_err_cyc", first_set(S_ERR, 0, 24), 5);
    chk("dup_err_cnt", count_set(S_ERR, 0, 24), 1);
    chk("dup_done_cyc", first_set(S_DONE, 0, 24), 13);
    chk("dup_done_cnt", count_set(S_DONE, 0, 24), 1);
    chk("dup_feed_cnt", count_set(S_FEED, 0, 24), 10);

    // Rise coinciding with DONE: ignored, err next cycle, no chaining.
    pat = 64'h1 | (64'h1 << 13);
    record(pat, 30);
    chk("done_rise_done_cyc", first_set(S_DONE, 0, 30), 13);
    chk("done_rise_err_cyc", first_set(S_ERR, 0, 30), 14);
    chk("done_rise_err_cnt", count_set(S_ERR, 0, 30), 1);
    chk("done_rise_no_rerun", count_set(S_BUSY, 14, 30), 0);

    // Start held high for 30 cycles, dropped, then raised again.
    pat = ((64'h1 << 30) - 64'h1) | (((64'h1 << 9) - 64'h1) << 32);
    record(pat, 50);
    chk("held_first_done", first_set(S_DONE, 0, 32), 13);
    chk("held_one_run", count_set(S_DONE, 0, 32), 1);
    chk("held_second_done", first_set(S_DONE, 32, 50), 45);
    chk("held_total_done", count_set(S_DONE, 0, 50), 2);
    chk("held_err_cnt", count_set(S_ERR, 0, 50), 0);

    // Async reset at feed step t=5 of a 4x4x4 run.
    set_dims(2'd3, 2'd3, 2'd3, 1'b0);
    bus.start_i = 1'b1;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    chk("rst_mid_feed_en", int'(bus.feed_en_o), 1);
    chk("rst_mid_step", int'(bus.step_o), 5);
    reset_ni = 1'b0;
    #1;
    chk("rst_mid_outputs", all_outs(), 0);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    record(64'h0, 20);
    chk("rst_mid_no_done", count_set(S_DONE, 0, 20), 0);
    chk("rst_mid_no_busy", count_set(S_BUSY, 0, 20), 0);
    record(64'h1, 20);
    chk("rst_rerun_done_cyc", first_set(S_DONE, 0, 20), 13);
    chk("rst_rerun_feed_cnt", count_set(S_FEED, 0, 20), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
